// File: rtl/irq_pkg.sv
// irq_pkg: register map, FSM encoding and vector layout shared by the interrupt controller
package irq_pkg;
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_VECTOR = 2'd2;
  localparam logic [1:0] IRQ_ACK = 2'd3;
  localparam int VEC_VALID_BIT = 31;
  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_IN_SERVICE} irq_state_e;
endpackage

// File: rtl/irq_if.sv
// irq_if: word-addressed register bus between the CPU side and the interrupt controller
interface irq_if;
  logic sel;
  logic [1:0] addr;
  logic mwe;
  logic mre;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output sel, addr, mwe, mre, wdata, input rdata);
  modport slave(input sel, addr, mwe, mre, wdata, output rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) idx = IDX_W'(i);
    valid = |req;
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt controller with vector/ack handshake
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  irq_if.slave             bus,
  input  logic [N_SRC-1:0] irq_in,
  output logic             cpu_irq,
  output logic [N_SRC-1:0] ack_out
);
  irq_state_e state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, mask_d, irq_q, ack_q, ack_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d, best;
  logic [31:0] rdata_q, rdata_d, vec;
  logic cpu_irq_q, cpu_irq_d, best_valid, wr, rd, ack_fire;
  logic [N_SRC-1:0] cur_onehot;
  irq_prio_enc #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_enc (
    .req  (pending_q & mask_q),
    .idx  (best),
    .valid(best_valid)
  );
  always_comb begin
    wr = bus.sel & bus.mwe;
    rd = bus.sel & bus.mre;
    cur_onehot = N_SRC'(1) << cur_idx_q;
    // upper wdata bits must be zero too, so an index >= N_SRC never matches
    ack_fire = wr && bus.addr == IRQ_ACK && state_q == ST_IN_SERVICE &&
               bus.wdata < 32'(N_SRC) && bus.wdata[IDX_W-1:0] == cur_idx_q;
    // new rising edges are OR-ed in last so a same-cycle set beats any clear
    pending_d = (pending_q & ~((wr && bus.addr == IRQ_PENDING ? bus.wdata[N_SRC-1:0] : '0) |
                               (ack_fire ? cur_onehot : '0))) | (irq_in & ~irq_q);
    mask_d = wr && bus.addr == IRQ_MASK ? bus.wdata[N_SRC-1:0] : mask_q;
    ack_d = ack_fire ? cur_onehot : '0;
    state_d = state_q;
    cur_idx_d = cur_idx_q;
    unique case (state_q)
      ST_IDLE: state_d = best_valid ? ST_ASSERT : ST_IDLE;
      ST_ASSERT: begin
        state_d = !best_valid ? ST_IDLE : (rd && bus.addr == IRQ_VECTOR) ? ST_IN_SERVICE : ST_ASSERT;
        cur_idx_d = state_d == ST_IN_SERVICE ? best : cur_idx_q;
      end
      ST_IN_SERVICE: state_d = ack_fire ? ST_IDLE : ST_IN_SERVICE;
      default: state_d = ST_IDLE;
    endcase
    cpu_irq_d = state_q == ST_ASSERT;
    vec = (state_q == ST_ASSERT && best_valid) ? ((32'(1) << VEC_VALID_BIT) | 32'(best)) :
          (state_q == ST_IN_SERVICE) ? ((32'(1) << VEC_VALID_BIT) | 32'(cur_idx_q)) : '0;
    rdata_d = !rd ? rdata_q :
              bus.addr == IRQ_PENDING ? 32'(pending_q) :
              bus.addr == IRQ_MASK ? 32'(mask_q) :
              bus.addr == IRQ_VECTOR ? vec : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pending_q <= '0;
      mask_q <= '0;
      irq_q <= '0;
      ack_q <= '0;
      cur_idx_q <= '0;
      rdata_q <= '0;
      cpu_irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
      irq_q <= irq_in;
      ack_q <= ack_d;
      cur_idx_q <= cur_idx_d;
      rdata_q <= rdata_d;
      cpu_irq_q <= cpu_irq_d;
    end
  end
  assign bus.rdata = rdata_q;
  assign cpu_irq = cpu_irq_q;
  assign ack_out = ack_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;
  logic clk = 0, reset = 1;
  logic [7:0] irq_in = '0;
  logic cpu_irq;
  logic [7:0] ack_out;
  logic [31:0] d;
  int n_cmp = 0, n_bad = 0;
  irq_if bus();
  irq_controller dut (.clk(clk), .reset(reset), .bus(bus), .irq_in(irq_in), .cpu_irq(cpu_irq), .ack_out(ack_out));
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.sel = 1; bus.mwe = 1; bus.addr = a; bus.wdata = v;
    tick();
    bus.sel = 0; bus.mwe = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.sel = 1; bus.mre = 1; bus.addr = a;
    tick();
    bus.sel = 0; bus.mre = 0;
    v = bus.rdata;
  endtask

  task automatic test_reset;
    bus.sel = 0; bus.mwe = 0; bus.mre = 0; bus.addr = 0; bus.wdata = 0;
    reset = 1;
    tick(2);
    reset = 0;
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_irq: got %b expected 0", cpu_irq); end
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL reset_ack_out: got %h expected 00", ack_out); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    rd(1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_mask: got %h expected 0", d); end
    rd(2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL idle_vector: got %h expected 0", d); end
  endtask

  task automatic test_timer_path;
    wr(1, 32'h01);
    irq_in[0] = 1;
    tick();
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL timer_early_irq: got %b expected 0", cpu_irq); end
    tick();
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL timer_early_irq2: got %b expected 0", cpu_irq); end
    tick();
    n_cmp++; if (cpu_irq !== 1'b1) begin n_bad++; $display("FAIL timer_irq: got %b expected 1", cpu_irq); end
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0000) begin n_bad++; $display("FAIL timer_vector: got %h expected 80000000", d); end
    tick();
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL timer_irq_fall: got %b expected 0", cpu_irq); end
    wr(3, 32'h0);
    n_cmp++; if (ack_out !== 8'h01) begin n_bad++; $display("FAIL timer_ack: got %h expected 01", ack_out); end
    tick();
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL timer_ack_len: got %h expected 00", ack_out); end
    rd(0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL timer_pending: got %h expected 0", d); end
    tick(3);
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL timer_retrigger: got %b expected 0", cpu_irq); end
    irq_in[0] = 0;
  endtask

  task automatic test_priority;
    wr(1, 32'hFF);
    irq_in = 8'h24;
    tick(3);
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0002) begin n_bad++; $display("FAIL prio_first: got %h expected 80000002", d); end
    wr(3, 32'h2);
    n_cmp++; if (ack_out !== 8'h04) begin n_bad++; $display("FAIL prio_ack2: got %h expected 04", ack_out); end
    tick(2);
    n_cmp++; if (cpu_irq !== 1'b1) begin n_bad++; $display("FAIL prio_reassert: got %b expected 1", cpu_irq); end
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0005) begin n_bad++; $display("FAIL prio_second: got %h expected 80000005", d); end
    wr(3, 32'h5);
    n_cmp++; if (ack_out !== 8'h20) begin n_bad++; $display("FAIL prio_ack5: got %h expected 20", ack_out); end
    irq_in = 0;
    tick();
  endtask

  task automatic test_masking;
    wr(1, 32'h0);
    irq_in[3] = 1;
    tick();
    rd(0, d);
    n_cmp++; if (d !== 32'h08) begin n_bad++; $display("FAIL mask_pending: got %h expected 08", d); end
    tick(2);
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL mask_blocked: got %b expected 0", cpu_irq); end
    wr(1, 32'h08);
    tick();
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL mask_early: got %b expected 0", cpu_irq); end
    tick();
    n_cmp++; if (cpu_irq !== 1'b1) begin n_bad++; $display("FAIL mask_enable: got %b expected 1", cpu_irq); end
    rd(2, d);
    wr(3, 32'h3);
    n_cmp++; if (ack_out !== 8'h08) begin n_bad++; $display("FAIL mask_ack: got %h expected 08", ack_out); end
    irq_in = 0;
    tick();
  endtask

  task automatic test_wrong_ack;
    wr(1, 32'hFF);
    irq_in[1] = 1;
    tick(3);
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0001) begin n_bad++; $display("FAIL wack_vector: got %h expected 80000001", d); end
    wr(3, 32'h4);
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL wack_pulse: got %h expected 00", ack_out); end
    wr(3, 32'h9);
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL wack_range: got %h expected 00", ack_out); end
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0001) begin n_bad++; $display("FAIL wack_still: got %h expected 80000001", d); end
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL wack_irq: got %b expected 0", cpu_irq); end
    wr(3, 32'h1);
    n_cmp++; if (ack_out !== 8'h02) begin n_bad++; $display("FAIL wack_right: got %h expected 02", ack_out); end
    irq_in = 0;
    rd(2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL wack_idle_vector: got %h expected 0", d); end
  endtask

  task automatic test_race;
    wr(1, 32'h0);
    bus.sel = 1; bus.mwe = 1; bus.addr = 0; bus.wdata = 32'h10;
    irq_in[4] = 1;
    tick();
    bus.sel = 0; bus.mwe = 0;
    rd(0, d);
    n_cmp++; if (d !== 32'h10) begin n_bad++; $display("FAIL race_set_wins: got %h expected 10", d); end
    wr(0, 32'h10);
    rd(0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL race_w1c: got %h expected 0", d); end
    bus.sel = 1; bus.mwe = 1; bus.mre = 1; bus.addr = 1; bus.wdata = 32'h55;
    tick();
    bus.sel = 0; bus.mwe = 0; bus.mre = 0;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rw_old_value: got %h expected 0", bus.rdata); end
    rd(1, d);
    n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL rw_new_value: got %h expected 55", d); end
    irq_in = 0;
  endtask

  task automatic test_reset_mid_service;
    wr(1, 32'hFF);
    irq_in[6] = 1;
    tick(3);
    rd(2, d);
    n_cmp++; if (d !== 32'h8000_0006) begin n_bad++; $display("FAIL rst_vector: got %h expected 80000006", d); end
    reset = 1; irq_in = 0;
    tick();
    reset = 0;
    n_cmp++; if (cpu_irq !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_irq: got %b expected 0", cpu_irq); end
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL rst_ack: got %h expected 00", ack_out); end
    rd(0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_pending: got %h expected 0", d); end
    n_cmp++; if (ack_out !== 8'h00) begin n_bad++; $display("FAIL rst_no_ack: got %h expected 00", ack_out); end
    rd(1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mask: got %h expected 0", d); end
    rd(2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_vec: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_timer_path();
    test_priority();
    test_masking();
    test_wrong_ack();
    test_race();
    test_reset_mid_service();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
